// File: rtl/line_feeder_pkg.sv
// Shared state encodings, counter-width helpers and credit limit for line_stream_feeder.
package line_feeder_pkg;

  localparam int CREDIT_MAX = 3;

  typedef logic [2:0] stateT;

  localparam stateT IDLE     = 3'd0;
  localparam stateT PRIME    = 3'd1;
  localparam stateT WAIT     = 3'd2;
  localparam stateT LINE     = 3'd3;
  localparam stateT PAD_WAIT = 3'd4;
  localparam stateT PAD      = 3'd5;
  localparam stateT DONE     = 3'd6;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lineCntWidth(input int height, input int pad);
    return $clog2(height + pad + 1);
  endfunction

endpackage

// File: rtl/intr_credit_counter.sv
// Registers the core interrupt, detects its rising edge and keeps a saturating
// count of lines the core is ready to accept.
module intr_credit_counter
  import line_feeder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       intr,
  input  logic       consume,
  output logic [1:0] credits
);

  logic intrQ;
  logic intrQ2;
  logic rise;

  assign rise = intrQ && !intrQ2;

  // An edge that coincides with a consume cancels out, so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      intrQ   <= 1'b0;
      intrQ2  <= 1'b0;
      credits <= 2'd0;
    end else begin
      intrQ  <= intr;
      intrQ2 <= intrQ;
      if (clr) begin
        credits <= 2'd0;
      end else if (rise && !consume && credits != 2'(CREDIT_MAX)) begin
        credits <= credits + 2'd1;
      end else if (!rise && consume && credits != 2'd0) begin
        credits <= credits - 2'd1;
      end
    end
  end

endmodule

// File: rtl/line_stream_feeder.sv
// Streams raster pixels from a frame source into the line-buffer core: primes it,
// then sends one line per core interrupt, then appends zero padding lines.
//
// state    | meaning
// IDLE     | waiting for i_start
// PRIME    | sending the first lines back to back
// WAIT     | waiting for a credit to send the next image line
// LINE     | sending one image line from the source
// PAD_WAIT | waiting for a credit to send a padding line, or for drain
// PAD      | sending one all-zero line
// DONE     | frame complete, cycle count frozen
module line_stream_feeder
  import line_feeder_pkg::*;
#(
  parameter int IMG_WIDTH   = 3840,
  parameter int IMG_HEIGHT  = 2160,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int DATA_W      = 8
) (
  input  logic                                             axi_clk,
  input  logic                                             axi_reset,
  input  logic                                             i_start,
  input  logic [DATA_W-1:0]                                i_src_data,
  input  logic                                             i_src_valid,
  output logic                                             o_src_ready,
  output logic [DATA_W-1:0]                                o_data,
  output logic                                             o_data_valid,
  input  logic                                             i_data_ready,
  input  logic                                             i_intr,
  output logic                                             o_busy,
  output logic                                             o_done,
  output logic [lineCntWidth(IMG_HEIGHT, PAD_LINES)-1:0]   o_line_cnt,
  output logic [31:0]                                      o_cycle_cnt
);

  localparam int PIX_W     = cntWidth(IMG_WIDTH);
  localparam int LINE_W    = lineCntWidth(IMG_HEIGHT, PAD_LINES);
  localparam int PRIME_EFF = (IMG_HEIGHT <= PRIME_LINES) ? IMG_HEIGHT : PRIME_LINES;

  localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] IMG_LINES  = LINE_W'(IMG_HEIGHT);
  localparam logic [LINE_W-1:0] ALL_LINES  = LINE_W'(IMG_HEIGHT + PAD_LINES);
  localparam logic [LINE_W-1:0] PRIME_LAST = LINE_W'(PRIME_EFF - 1);
  // A short image is fully consumed by priming and goes straight to padding.
  localparam stateT PRIME_NEXT = (IMG_HEIGHT <= PRIME_LINES) ? PAD_WAIT : WAIT;

  stateT            state;
  stateT            stateNxt;
  logic [PIX_W-1:0] pixCnt;
  logic [1:0]       credits;
  logic             creditAvail;
  logic             consume;
  logic             startGo;
  logic             srcPhase;
  logic             padPhase;
  logic             canLoad;
  logic             load;
  logic             lineEnd;
  logic             cycleRun;

  assign srcPhase    = (state == PRIME) || (state == LINE);
  assign padPhase    = (state == PAD);
  assign canLoad     = !o_data_valid || i_data_ready;
  assign o_src_ready = srcPhase && canLoad;
  assign load        = (o_src_ready && i_src_valid) || (padPhase && canLoad);
  assign lineEnd     = load && (pixCnt == LAST_PIX);
  assign startGo     = i_start && ((state == IDLE) || (state == DONE));
  assign creditAvail = (credits != 2'd0);
  assign cycleRun    = (state == WAIT) || (state == LINE) || (state == PAD_WAIT) || (state == PAD);
  assign o_busy      = (state != IDLE) && (state != DONE);
  assign o_done      = (state == DONE);

  intr_credit_counter uCredits (
    .clk     (axi_clk),
    .rst     (axi_reset),
    .clr     (startGo),
    .intr    (i_intr),
    .consume (consume),
    .credits (credits)
  );

  always_comb begin
    stateNxt = state;
    consume  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (i_start) stateNxt = PRIME;
      end
      PRIME: begin
        if (lineEnd && o_line_cnt == PRIME_LAST) stateNxt = PRIME_NEXT;
      end
      WAIT: begin
        if (o_line_cnt >= IMG_LINES) begin
          stateNxt = PAD_WAIT;
        end else if (creditAvail) begin
          consume  = 1'b1;
          stateNxt = LINE;
        end
      end
      LINE: begin
        if (lineEnd) stateNxt = WAIT;
      end
      PAD_WAIT: begin
        if (o_line_cnt < ALL_LINES) begin
          if (creditAvail) begin
            consume  = 1'b1;
            stateNxt = PAD;
          end
        end else if (!o_data_valid) begin
          stateNxt = DONE;
        end
      end
      PAD: begin
        if (lineEnd) stateNxt = PAD_WAIT;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state        <= IDLE;
      pixCnt       <= '0;
      o_line_cnt   <= '0;
      o_cycle_cnt  <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else begin
      state <= stateNxt;
      // An unloaded register slot drains, so starvation shows up as a valid gap.
      if (canLoad) begin
        o_data_valid <= load;
        if (load) o_data <= padPhase ? '0 : i_src_data;
      end
      if (startGo) begin
        pixCnt      <= '0;
        o_line_cnt  <= '0;
        o_cycle_cnt <= '0;
      end else begin
        if (load) pixCnt <= lineEnd ? '0 : pixCnt + PIX_W'(1);
        if (lineEnd) o_line_cnt <= o_line_cnt + LINE_W'(1);
        if (cycleRun) o_cycle_cnt <= o_cycle_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/line_stream_feeder.md
Name: line_stream_feeder

Overview:
- Transmit-side counterpart to imageProcessTop's slave pixel interface.
- Pulls raster-order pixels from a frame source (BRAM/FIFO reader) and streams them into the line-buffer core.
- Primes the core's line buffers, then sends one line per rising edge of the core's o_intr, then appends zero padding lines.
- Counts cycles from end of priming to the last pixel sent, for benchmarking.

Parameters:
IMG_WIDTH, 3840, pixels per line
IMG_HEIGHT, 2160, image lines read from source
PRIME_LINES, 4, lines sent before waiting for the first interrupt
PAD_LINES, 2, all-zero lines appended after the image
DATA_W, 8, pixel width

Ports:
axi_clk  in  1  clock
axi_reset  in  1  synchronous active-high reset
i_start  in  1  one-cycle start pulse; honoured only in IDLE or DONE
i_src_data  in  DATA_W  source pixel
i_src_valid  in  1  source pixel available
o_src_ready  out  1  feeder accepts source pixel this cycle
o_data  out  DATA_W  pixel to core (i_data of core)
o_data_valid  out  1  pixel valid to core
i_data_ready  in  1  core ready (o_data_ready of core)
i_intr  in  1  core line-consumed interrupt (o_intr of core)
o_busy  out  1  high in any state except IDLE and DONE
o_done  out  1  high in DONE
o_line_cnt  out  clog2(IMG_HEIGHT+PAD_LINES+1)  lines fully sent
o_cycle_cnt  out  32  cycles from leaving PRIME to entering DONE

Behaviour:
- Reset: all outputs 0, state IDLE, credits 0, counters 0. Reset mid-frame aborts immediately, with no flush. Source data in flight is the source's problem.
- Output register: o_data/o_data_valid are registered. The register loads when empty or when i_data_ready=1.
- Source transfer: o_src_ready = sending_state && (!o_data_valid || i_data_ready). A transfer occurs on o_src_ready && i_src_valid.
- Padding lines: source is not read (o_src_ready=0). The output register loads 0 each cycle it can load.
- Pixel counter: counts loads into the output register, 0..IMG_WIDTH-1. On the last pixel of a line it wraps to 0 and increments o_line_cnt.
- Interrupt credits: i_intr is registered and its rising edge detected. Each edge adds one credit, saturating at 3. Consuming a credit on entry to LINE/PAD subtracts 1. A simultaneous edge and consume leaves the count unchanged. Edges are never lost while a line is in flight.
- States:
  - IDLE: on i_start go to PRIME and clear o_line_cnt, o_cycle_cnt and credits.
  - PRIME: send PRIME_LINES*IMG_WIDTH pixels back to back, then go to WAIT. If IMG_HEIGHT <= PRIME_LINES, send IMG_HEIGHT lines, then go to PAD_WAIT.
  - WAIT: if credit>0 and o_line_cnt < IMG_HEIGHT, consume and go to LINE. If o_line_cnt == IMG_HEIGHT, go to PAD_WAIT.
  - LINE: send IMG_WIDTH source pixels, then return to WAIT.
  - PAD_WAIT: if credit>0 and o_line_cnt < IMG_HEIGHT+PAD_LINES, consume and go to PAD. If all lines are sent, go to DONE once the output register is empty.
  - PAD: send IMG_WIDTH zeros, then return to PAD_WAIT.
  - DONE: o_done=1. i_start restarts as from IDLE.
- Line spacing: o_data_valid drops for at least one cycle between lines after priming, because the WAIT/PAD_WAIT visit costs one cycle.
- o_cycle_cnt increments every cycle in WAIT, LINE, PAD_WAIT and PAD. It holds in DONE.
- Backpressure (i_data_ready=0): the output register holds its value, valid stays high, and no source read occurs.
- Source starvation: o_data_valid goes low after the held pixel drains. There are no gaps otherwise.
- i_intr during PRIME counts as a credit.
- i_start outside IDLE/DONE is ignored.

Decomposition:
- Package line_feeder_pkg holds:
  - state enum (IDLE, PRIME, WAIT, LINE, PAD_WAIT, PAD, DONE)
  - helper functions for counter widths
  - CREDIT_MAX=3 constant
- Sub-module intr_credit_counter: input register, rising-edge detect, and saturating 2-bit credit counter with a consume input.
- The top level holds the FSM, pixel/line counters, output register and cycle counter.

Test Plan:
(Benches use IMG_WIDTH=8, IMG_HEIGHT=6, PRIME_LINES=4, PAD_LINES=2 unless stated.)
1. Nominal frame: source always valid with ramp pixels, i_data_ready=1, i_start pulse -> exactly 32 contiguous valid pixels 0..31 with no gaps, then o_data_valid=0 and o_line_cnt=4.
2. One i_intr pulse per line after priming -> 8 more pixels each. The final 2 lines are zeros. o_done=1 after o_line_cnt=8. 64 valid beats total, matching the source order.
3. Two i_intr pulses 2 cycles apart while in LINE -> both credited. The next two lines go out with only the one-cycle WAIT gap between them.
4. i_data_ready low for 5 cycles mid-line -> o_data held stable, no source reads, no duplicate or dropped pixel.
5. axi_reset asserted mid-LINE -> next cycle all outputs 0 and state IDLE. A new i_start replays the frame from pixel 0.
6. i_src_valid toggling every other cycle -> o_data_valid gaps follow the source, and pixel order and count stay correct.
